// File: rtl/dec_stream_if.sv
// dec_stream_if: stream bundle for the binary-to-one-hot decoder.
//   in_valid/in_ready/in/en : upstream code handshake (en travels with the code)
//   out_valid/out_ready/out : downstream one-hot word handshake
//   cnt                     : saturating count of accepted codes
// Modports:
//   slave  - the decoder's view (consumes codes, produces words)
//   master - the environment's view (produces codes, consumes words)
interface dec_stream_if #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in;
    logic             en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic [CNT_W-1:0] cnt;

    modport slave (
        input  in_valid, in, en, out_ready,
        output in_ready, out_valid, out, cnt
    );

    modport master (
        output in_valid, in, en, out_ready,
        input  in_ready, out_valid, out, cnt
    );
endinterface

// File: rtl/dec_stream.sv
// dec_stream: registered, streaming binary-to-one-hot decoder with a 2-entry skid buffer.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears all buffered words and the counter
//   bus   - dec_stream_if.slave: code in (in_valid/in_ready/in/en),
//           one-hot word out (out_valid/out_ready/out), accepted-code count (cnt)
// The interface instance must be built with the same IN_W/OUT_W/CNT_W as this module.
// OUT_W must equal 2**IN_W.
module dec_stream #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    dec_stream_if.slave  bus
);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StTwo
    } state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] main_q, main_d;
    logic [OUT_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             xfer;
    logic [OUT_W-1:0] word;

    // Handshake flags come from state only, so in_ready never sees out_ready.
    assign bus.in_ready  = (state_q != StTwo);
    assign bus.out_valid = (state_q != StEmpty);
    // main_q is kept at zero whenever the buffer is empty, so out reads 0 then.
    assign bus.out       = main_q;
    assign bus.cnt       = cnt_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign xfer   = bus.out_valid && bus.out_ready;

    always_comb begin
        word = '0;
        if (bus.en) begin
            word[bus.in] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = word;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (accept && xfer) begin
                    main_d = word;
                end else if (accept) begin
                    skid_d  = word;
                    state_d = StTwo;
                end else if (xfer) begin
                    main_d  = '0;
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (xfer) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = StOne;
                end
            end
            default: begin
                state_d = StEmpty;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dec_stream.sv
module tb_dec_stream;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    dec_stream_if #(.IN_W(3), .OUT_W(8), .CNT_W(16)) bus ();
    dec_stream_if #(.IN_W(3), .OUT_W(8), .CNT_W(4))  sbus ();

    dec_stream #(.IN_W(3), .OUT_W(8), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    dec_stream #(.IN_W(3), .OUT_W(8), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 3'd5;
        bus.en        = 1'b1;
        bus.out_ready = 1'b0;
        sbus.in_valid = 1'b0;
        sbus.in       = 3'd0;
        sbus.en       = 1'b1;
        sbus.out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_valid got %b want 0", bus.out_valid);
        end
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.out !== 8'h00) begin
            errors++;
            $display("FAIL reset_out got %h want 00", bus.out);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", bus.cnt);
        end
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.en        = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in       = 3'(i);
            tick();
            exp = 8'h01 << i;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== exp) begin
                errors++;
                $display("FAIL sweep_out[%0d] got v=%b %h want v=1 %h", i, bus.out_valid,
                         bus.out, exp);
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sweep_in_ready[%0d] got %b want 1", i, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.cnt !== 16'd8) begin
            errors++;
            $display("FAIL sweep_cnt got %0d want 8", bus.cnt);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00) begin
            errors++;
            $display("FAIL sweep_drain got v=%b %h want v=0 00", bus.out_valid, bus.out);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.en        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in        = 3'd3;
        tick();
        bus.in = 3'd5;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 8'h08 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_first got v=%b %h want v=1 08", bus.out_valid, bus.out);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready_full got %b want 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out !== 8'h08 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got %h rdy=%b want 08 rdy=0", bus.out, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out !== 8'h20 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got v=%b %h want v=1 20", bus.out_valid, bus.out);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_in_ready_back got %b want 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00) begin
            errors++;
            $display("FAIL bp_drain got v=%b %h want v=0 00", bus.out_valid, bus.out);
        end
        checks++;
        if (bus.cnt !== 16'd10) begin
            errors++;
            $display("FAIL bp_cnt got %0d want 10", bus.cnt);
        end
    endtask

    task automatic test_enable_low();
        bus.out_ready = 1'b0;
        bus.en        = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in        = 3'd7;
        tick();
        bus.in_valid = 1'b0;
        bus.en       = 1'b1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 8'h00) begin
            errors++;
            $display("FAIL en_low_out got v=%b %h want v=1 00", bus.out_valid, bus.out);
        end
        checks++;
        if (bus.cnt !== 16'd11) begin
            errors++;
            $display("FAIL en_low_cnt got %0d want 11", bus.cnt);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL en_low_drain got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        // Accept and transfer on the same edges while a word is already held.
        bus.out_ready = 1'b1;
        bus.en        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in        = 3'd2;
        tick();
        bus.in = 3'd4;
        tick();
        checks++;
        if (bus.out !== 8'h10 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got %h rdy=%b want 10 rdy=1", bus.out, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_dup got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.en        = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in        = 3'd1;
        tick();
        bus.in = 3'd2;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 8'h02 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_full got %h rdy=%b want 02 rdy=0", bus.out, bus.in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 8'h00) begin
            errors++;
            $display("FAIL mid_async_clear got v=%b %h want v=0 00", bus.out_valid, bus.out);
        end
        checks++;
        if (bus.cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_cnt got %0d want 0", bus.cnt);
        end
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in        = 3'd6;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 8'h40) begin
            errors++;
            $display("FAIL mid_after got v=%b %h want v=1 40", bus.out_valid, bus.out);
        end
        checks++;
        if (bus.cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_after_cnt got %0d want 1", bus.cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        logic [3:0] exp;
        sbus.out_ready = 1'b1;
        sbus.en        = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sbus.in_valid = 1'b1;
            sbus.in       = 3'(i);
            tick();
            exp = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            if (i == 13 || i == 14 || i == 19) begin
                checks++;
                if (sbus.cnt !== exp) begin
                    errors++;
                    $display("FAIL sat_cnt[%0d] got %0d want %0d", i, sbus.cnt, exp);
                end
            end
        end
        sbus.in_valid = 1'b0;
        tick();
        checks++;
        if (sbus.cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got %0d want 15", sbus.cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sweep();
        test_backpressure();
        test_enable_low();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
